// File: rtl/rv32_pkg.sv
// Shared RV32 data-memory definitions: funct3 width/sign codes and the
// dmem_resp controller state type.
package rv32_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_resp_state_t;

   // Stores have no unsigned variants; loads accept all five codes.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return f3 inside {F3_B, F3_H, F3_W};
      else    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for RV32 loads/stores: byte enables, store data
// replication and load extract/extend. Macro DMEM_RESP_MISALIGN_TRAP_EN.
module dmem_align
   import rv32_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] word,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic [31:0] rdata,
   output logic        fault
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        misalign;

   always_comb begin
      be         = '0;
      lane_wdata = '0;
      rdata      = '0;
      misalign   = 1'b0;
      half_sel   = offset[1] ? word[31:16] : word[15:0];
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase

      // Half/word lanes ignore the low offset bits, so untrapped
      // misaligned accesses fall back to natural alignment.
      case (funct3)
         F3_B, F3_BU: begin
            be         = 4'b0001 << offset;
            lane_wdata = {4{wdata[7:0]}};
            rdata      = (funct3 == F3_BU) ? {24'b0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
         end
         F3_H, F3_HU: begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata[15:0]}};
            rdata      = (funct3 == F3_HU) ? {16'b0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            misalign   = offset[0];
         end
         F3_W: begin
            be         = '1;
            lane_wdata = wdata;
            rdata      = word;
            misalign   = |offset;
         end
         default: ;
      endcase
   end

`ifdef DMEM_RESP_MISALIGN_TRAP_EN
   assign fault = misalign;
`else
   assign fault = 1'b0 & misalign;
`endif

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding RV32 data-memory responder with programmable wait
// states and registered response. Macro DMEM_RESP_MISALIGN_TRAP_EN.
module dmem_resp
   import rv32_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   dmem_resp_state_t state;
   logic [3:0]  cnt;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [2:0]  c_f3;

   logic        e_we;
   logic [31:0] e_addr;
   logic [31:0] e_wdata;
   logic [2:0]  e_f3;
   logic [AW-1:0] widx;
   logic [31:0] mem_word;
   logic        in_range;
   logic        acc_err;
   logic        fault;
   logic        commit;
   logic [3:0]  be;
   logic [31:0] lane_wdata;
   logic [31:0] ld_data;
   logic [31:0] rsp_next;

   // With zero wait states the access completes on the accept edge, so the
   // live request is used in IDLE and the captured copy otherwise.
   always_comb begin
      if (state == IDLE) begin
         e_we    = req_we;
         e_addr  = req_addr;
         e_wdata = req_wdata;
         e_f3    = req_funct3;
      end else begin
         e_we    = c_we;
         e_addr  = c_addr;
         e_wdata = c_wdata;
         e_f3    = c_f3;
      end
   end

   assign widx     = e_addr[AW+1:2];
   assign in_range = {2'b00, e_addr[31:2]} < DEPTH_U;
   assign mem_word = mem[widx];
   assign acc_err  = !in_range || !f3_legal(e_we, e_f3) || fault;
   assign rsp_next = (acc_err || e_we) ? '0 : ld_data;
   assign commit   = !rst &&
                     (((state == IDLE) && req_valid && req_ready && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0)));

   dmem_align u_align (
      .funct3     (e_f3),
      .offset     (e_addr[1:0]),
      .wdata      (e_wdata),
      .word       (mem_word),
      .be         (be),
      .lane_wdata (lane_wdata),
      .rdata      (ld_data),
      .fault      (fault)
   );

   always_ff @(posedge clk) begin
      if (commit && e_we && !acc_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= lane_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         c_we      <= 1'b0;
         c_addr    <= '0;
         c_wdata   <= '0;
         c_f3      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  c_we      <= req_we;
                  c_addr    <= req_addr;
                  c_wdata   <= req_wdata;
                  c_f3      <= req_funct3;
                  req_ready <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_next;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_next;
                  rsp_err   <= acc_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized bench for dmem_resp against a byte-array reference model;
// covers a WAIT_CYCLES=1 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_resp;
   import rv32_pkg::*;

   localparam int W = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [2:0]  req_funct3;

   logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
   logic [2:0]  req_funct30;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] rm [4096];

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
      .req_funct3(req_funct30), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: access size 1/2/4 bytes, error rules, little-endian bytes.
   task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, output logic [31:0] rd, output logic er);
      int          size;
      logic [31:0] base, v;
      logic        legal;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = 1 << f3[1:0];
      rd    = '0;
      er    = 1'b0;
      if (!legal || addr[31:2] >= 30'd1024) begin
         er = 1'b1;
         return;
      end
      base = addr - (addr % size);
`ifdef DMEM_RESP_MISALIGN_TRAP_EN
      if (base != addr) begin
         er = 1'b1;
         return;
      end
`endif
      if (we) begin
         for (int i = 0; i < size; i++) rm[base + i] = wdata[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = rm[base + i];
         if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
         if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
         rd = v;
      end
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input int hold, input string tag);
      logic [31:0] er;
      logic        ee;
      int          k;
      ref_access(we, addr, wdata, f3, er, ee);
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_rdy"}, req_ready, 1'b1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rsp_valid && k < 20);
      chk({tag, "_lat"}, k, 1 + W);
      chk({tag, "_rd"}, rsp_rdata, er);
      chk({tag, "_err"}, rsp_err, ee);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_v"}, rsp_valid, 1'b1);
         chk({tag, "_hold_rd"}, rsp_rdata, er);
         chk({tag, "_hold_err"}, rsp_err, ee);
         chk({tag, "_hold_rdy"}, req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_done_v"}, rsp_valid, 1'b0);
      chk({tag, "_done_rdy"}, req_ready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      logic [31:0] a, old_rd;
      logic        old_er;
      int          last, nacc;
      logic        prev_acc;

      rst = 1'b1;
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_funct3 = '0; rsp_ready = 0;
      req_valid0 = 0; req_we0 = 0; req_addr0 = '0; req_wdata0 = '0; req_funct30 = '0; rsp_ready0 = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_req_ready", req_ready, 1'b0);
         chk("rst_rsp_valid", rsp_valid, 1'b0);
         chk("rst_rdata", rsp_rdata, 32'h0);
         chk("rst_err", rsp_err, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_rdy", req_ready, 1'b1);

      for (int w = 0; w < 64; w++) do_req(1'b1, 32'(w * 4), $urandom, F3_W, 0, "fill");

      do_req(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 0, "sw10");
      do_req(1'b0, 32'h10, 32'h0, F3_W, 0, "lw10");
      do_req(1'b1, 32'h20, 32'h00, F3_B, 0, "sb20");
      do_req(1'b1, 32'h21, 32'h80, F3_B, 0, "sb21");
      do_req(1'b0, 32'h21, 32'h0, F3_B, 0, "lb21");
      do_req(1'b0, 32'h21, 32'h0, F3_BU, 0, "lbu21");
      do_req(1'b1, 32'h22, 32'h8001, F3_H, 0, "sh22");
      do_req(1'b0, 32'h22, 32'h0, F3_HU, 0, "lhu22");
      do_req(1'b0, 32'h20, 32'h0, F3_W, 0, "lw20");
      do_req(1'b0, 32'h10, 32'h0, F3_W, 5, "bp");

      do_req(1'b0, 32'h1000, 32'h0, F3_W, 0, "oob");
      do_req(1'b0, 32'h10, 32'h0, 3'b011, 0, "f3_011");
      do_req(1'b1, 32'h10, 32'h1, F3_BU, 0, "sbu_bad");
      do_req(1'b1, 32'h06, 32'hA5A5_5A5A, F3_W, 0, "sw06");
      do_req(1'b0, 32'h04, 32'h0, F3_W, 0, "lw04");

      // Reset during WAIT must discard the captured store.
      ref_access(1'b0, 32'h40, 32'h0, F3_W, old_rd, old_er);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_funct3 = F3_W;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_valid", rsp_valid, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      do_req(1'b0, 32'h40, 32'h0, F3_W, 0, "rst_lw40");

      for (int n = 0; n < 150; n++) begin
         a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'h3FFF)
                                         : 32'($urandom_range(0, 255));
         do_req(1'($urandom_range(0, 1)), a, $urandom, f3tab[$urandom_range(0, 9)],
                $urandom_range(0, 2), "rnd");
      end

      // Zero-wait instance: latency 1 and one accept every 2 cycles.
      @(negedge clk);
      chk("w0_rdy", req_ready0, 1'b1);
      req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'hCAFEF00D; req_funct30 = F3_W;
      @(posedge clk);
      #1 req_valid0 = 1'b0;
      @(negedge clk);
      chk("w0_sw_valid", rsp_valid0, 1'b1);
      chk("w0_sw_err", rsp_err0, 1'b0);
      rsp_ready0 = 1'b1;
      @(posedge clk);
      #1;
      req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h8; req_funct30 = F3_W;
      last = -1; nacc = 0; prev_acc = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (prev_acc) begin
            chk("w0_lat1", rsp_valid0, 1'b1);
            chk("w0_rd", rsp_rdata0, 32'hCAFEF00D);
         end
         prev_acc = req_ready0;
         if (req_ready0) begin
            if (last >= 0) chk("w0_b2b_gap", c - last, 2);
            last = c;
            nacc++;
         end
      end
      chk("w0_nacc", nacc, 8);
      req_valid0 = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
